// File: rtl/stack_ctl_pkg.sv
// Shared definitions for the stack controller.
// Holds the 2-bit operation encoding, the controller FSM states and a
// small helper that decides whether an operation is legal at the
// current occupancy.
package stack_ctl_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Push needs room, pop/replace need an element; no-op is never legal.
  function automatic logic op_legal(input logic [1:0] op, input logic empty,
                                    input logic full);
    case (op)
      OP_PUSH:          return !full;
      OP_POP, OP_REPL:  return !empty;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stack_ctl_if.sv
// Request/grant bus between the two requesters (core, debug) and the
// stack controller.
//   core_req/core_op/core_din -> controller, core_gnt <- controller
//   dbg_req/dbg_op/dbg_din    -> controller, dbg_gnt  <- controller
// master: requester side; slave: controller side.
interface stack_ctl_if #(parameter int WIDTH = 16);
  logic             core_req;
  logic [1:0]       core_op;
  logic [WIDTH-1:0] core_din;
  logic             core_gnt;
  logic             dbg_req;
  logic [1:0]       dbg_op;
  logic [WIDTH-1:0] dbg_din;
  logic             dbg_gnt;

  modport master (output core_req, core_op, core_din, dbg_req, dbg_op, dbg_din,
                  input  core_gnt, dbg_gnt);
  modport slave  (input  core_req, core_op, core_din, dbg_req, dbg_op, dbg_din,
                  output core_gnt, dbg_gnt);
endinterface

// File: rtl/stack_rr_arb.sv
// Two-way round-robin arbiter.
//   req[0]/gnt[0]: core, req[1]/gnt[1]: debug.
// Grants are combinational; on a tie the requester that was not granted
// most recently wins. Out of reset the core wins the first tie.
module stack_rr_arb (
  input  logic       clk,
  input  logic       resetq,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_dbg;  // 1: debug wins the next tie

  assign gnt[0] = req[0] & (~req[1] | ~prio_dbg);
  assign gnt[1] = req[1] & (~req[0] |  prio_dbg);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)     prio_dbg <= 1'b0;
    else if (gnt[0]) prio_dbg <= 1'b1;
    else if (gnt[1]) prio_dbg <= 1'b0;
  end

endmodule

// File: rtl/stack_ctl.sv
// Stack controller: arbitrates core and debug stack operations, drives
// the external stack datapath and tracks occupancy and errors.
// Ports:
//   clk, resetq       clock, async active-low reset
//   bus (slave)       core/debug req, op, din in; gnt out
//   flush             empty the stack (one FLUSH cycle, then RUN)
//   clr_err           clear sticky ovf/unf and leave HALT
//   stk_push/stk_pop  datapath strobes (both set = replace)
//   stk_in            datapath write data
//   stk_rst           sync reset of the datapath pointer
//   depth/empty/full  occupancy
//   ovf/unf           sticky overflow/underflow flags
module stack_ctl
  import stack_ctl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTHLOG2 = 3
) (
  input  logic                 clk,
  input  logic                 resetq,
  stack_ctl_if.slave           bus,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [WIDTH-1:0]     stk_in,
  output logic                 stk_rst,
  output logic [DEPTHLOG2:0]   depth,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf,
  output logic                 unf
);

  localparam logic [DEPTHLOG2:0] DEPTH_V = (DEPTHLOG2+1)'(1 << DEPTHLOG2);
  localparam logic [DEPTHLOG2:0] ONE     = {{DEPTHLOG2{1'b0}}, 1'b1};

  state_e     state;
  logic       active, core_ok, dbg_ok, core_bad, dbg_bad, ovf_evt, unf_evt;
  logic [1:0] gnt;
  logic [1:0] sel_op;

  assign empty = (depth == '0);
  assign full  = (depth == DEPTH_V);

  // Nothing is served in the FLUSH cycle or in a cycle asking for a flush.
  // Core is only served in RUN; debug is served in RUN and HALT.
  always_comb begin
    active   = (state != ST_FLUSH) && !flush;
    core_ok  = active && (state == ST_RUN) && bus.core_req &&
               op_legal(bus.core_op, empty, full);
    dbg_ok   = active && bus.dbg_req && op_legal(bus.dbg_op, empty, full);
    core_bad = active && (state == ST_RUN) && bus.core_req &&
               (bus.core_op != OP_NOP) && !op_legal(bus.core_op, empty, full);
    dbg_bad  = active && bus.dbg_req &&
               (bus.dbg_op != OP_NOP) && !op_legal(bus.dbg_op, empty, full);
    ovf_evt  = (core_bad && bus.core_op == OP_PUSH) ||
               (dbg_bad  && bus.dbg_op  == OP_PUSH);
    unf_evt  = (core_bad && bus.core_op != OP_PUSH) ||
               (dbg_bad  && bus.dbg_op  != OP_PUSH);
  end

  stack_rr_arb u_arb (
    .clk    (clk),
    .resetq (resetq),
    .req    ({dbg_ok, core_ok}),
    .gnt    (gnt)
  );

  assign bus.core_gnt = gnt[0];
  assign bus.dbg_gnt  = gnt[1];

  always_comb begin
    sel_op = OP_NOP;
    stk_in = '0;
    if (gnt[1]) begin
      sel_op = bus.dbg_op;
      stk_in = bus.dbg_din;
    end else if (gnt[0]) begin
      sel_op = bus.core_op;
      stk_in = bus.core_din;
    end
  end

  assign stk_push = sel_op[0];
  assign stk_pop  = sel_op[1];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state   <= ST_FLUSH;
      depth   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      stk_rst <= 1'b1;
    end else begin
      case (state)
        ST_FLUSH: begin
          state   <= ST_RUN;
          depth   <= '0;
          stk_rst <= 1'b0;
        end
        default: begin
          if (stk_push && !stk_pop)      depth <= depth + ONE;
          else if (stk_pop && !stk_push) depth <= depth - ONE;
          // A new error in the same cycle as clr_err keeps its flag set.
          ovf <= (ovf && !clr_err) || ovf_evt;
          unf <= (unf && !clr_err) || unf_evt;
          if (flush) begin
            state   <= ST_FLUSH;
            stk_rst <= 1'b1;
          end else if (state == ST_RUN && core_bad) begin
            state <= ST_HALT;
          end else if (state == ST_HALT && clr_err) begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctl.sv
module tb_stack_ctl;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        flush = 1'b0, clr_err = 1'b0;
  logic        stk_push, stk_pop, stk_rst, empty, full, ovf, unf;
  logic [15:0] stk_in;
  logic [3:0]  depth;

  int n_chk = 0;
  int n_fail = 0;

  stack_ctl_if #(.WIDTH(16)) bus ();

  stack_ctl #(.WIDTH(16), .DEPTHLOG2(3)) dut (
    .clk(clk), .resetq(resetq), .bus(bus), .flush(flush), .clr_err(clr_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in), .stk_rst(stk_rst),
    .depth(depth), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Simple stack datapath driven by the controller outputs.
  logic [15:0] dp_mem [8];
  int          dp_ptr = 0;
  always @(posedge clk) begin
    if (stk_rst) dp_ptr <= 0;
    else if (stk_push && stk_pop) begin
      if (dp_ptr > 0) dp_mem[dp_ptr-1] <= stk_in;
    end else if (stk_push) begin
      if (dp_ptr < 8) begin
        dp_mem[dp_ptr] <= stk_in;
        dp_ptr <= dp_ptr + 1;
      end
    end else if (stk_pop) begin
      if (dp_ptr > 0) dp_ptr <= dp_ptr - 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_top(input string nm, input int exp);
    if (dp_ptr > 0) chk(nm, int'(dp_mem[dp_ptr-1]), exp);
    else chk(nm, -1, exp);
  endtask

  typedef struct {
    logic cr; logic [1:0] cop; logic [15:0] cd;
    logic dr; logic [1:0] dop; logic [15:0] dd;
    logic fl, ce;
    logic cg, dg, sp, spo, srst;
    int   dep;
    logic ov, un;
    int   top;
  } vec_t;

  function automatic vec_t mk(input int cr, cop, cd, dr, dop, dd, fl, ce,
                              cg, dg, sp, spo, srst, dep, ov, un, top);
    vec_t v;
    v.cr = cr[0]; v.cop = cop[1:0]; v.cd = cd[15:0];
    v.dr = dr[0]; v.dop = dop[1:0]; v.dd = dd[15:0];
    v.fl = fl[0]; v.ce = ce[0];
    v.cg = cg[0]; v.dg = dg[0]; v.sp = sp[0]; v.spo = spo[0]; v.srst = srst[0];
    v.dep = dep; v.ov = ov[0]; v.un = un[0]; v.top = top;
    return v;
  endfunction

  task automatic drive(input logic cr, input logic [1:0] cop, input logic [15:0] cd,
                       input logic dr, input logic [1:0] dop, input logic [15:0] dd,
                       input logic fl, input logic ce);
    bus.core_req = cr; bus.core_op = cop; bus.core_din = cd;
    bus.dbg_req = dr;  bus.dbg_op = dop;  bus.dbg_din = dd;
    flush = fl; clr_err = ce;
  endtask

  // Reference model state
  logic [15:0] m_q[$];
  bit m_flushing, m_halted, m_core_next, m_ovf, m_unf;

  function automatic bit m_legal(input logic [1:0] op, input int n);
    if (op == 2'b01) return n < 8;
    if (op != 2'b00) return n > 0;
    return 0;
  endfunction

  vec_t tbl[32];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // 1=push 2=pop 3=replace
    tbl[0]  = mk(0,0,0,      0,0,0,     0,0, 0,0,0,0,1, 0,0,0,-1);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mk(1,1,i,     0,0,0,     0,0, 1,0,1,0,0, i-1,0,0,-1);
    tbl[9]  = mk(0,0,0,      0,0,0,     0,0, 0,0,0,0,0, 8,0,0,8);
    tbl[10] = mk(1,1,9,      0,0,0,     0,0, 0,0,0,0,0, 8,0,0,-1);
    tbl[11] = mk(1,2,0,      1,2,0,     0,0, 0,1,0,1,0, 8,1,0,-1);
    tbl[12] = mk(1,2,0,      0,0,0,     0,1, 0,0,0,0,0, 7,1,0,7);
    tbl[13] = mk(1,2,0,      0,0,0,     0,0, 1,0,0,1,0, 7,0,0,-1);
    tbl[14] = mk(0,0,0,      1,2,0,     0,0, 0,1,0,1,0, 6,0,0,-1);
    tbl[15] = mk(1,1,'h44,   0,0,0,     1,0, 0,0,0,0,0, 5,0,0,-1);
    tbl[16] = mk(1,1,'h44,   0,0,0,     0,0, 0,0,0,0,1, 5,0,0,-1);
    tbl[17] = mk(1,1,'h11,   1,1,'h21,  0,0, 1,0,1,0,0, 0,0,0,-1);
    tbl[18] = mk(1,1,'h12,   1,1,'h22,  0,0, 0,1,1,0,0, 1,0,0,-1);
    tbl[19] = mk(1,1,'h13,   1,1,'h23,  0,0, 1,0,1,0,0, 2,0,0,-1);
    tbl[20] = mk(1,1,'h14,   1,1,'h24,  0,0, 0,1,1,0,0, 3,0,0,-1);
    tbl[21] = mk(0,0,0,      1,2,0,     0,0, 0,1,0,1,0, 4,0,0,'h24);
    tbl[22] = mk(1,1,'h55,   0,0,0,     1,0, 0,0,0,0,0, 3,0,0,-1);
    tbl[23] = mk(1,1,'h55,   0,0,0,     0,0, 0,0,0,0,1, 3,0,0,-1);
    tbl[24] = mk(0,0,0,      1,2,0,     0,0, 0,0,0,0,0, 0,0,0,-1);
    tbl[25] = mk(1,1,'h31,   0,0,0,     0,0, 1,0,1,0,0, 0,0,1,-1);
    tbl[26] = mk(1,1,'h32,   0,0,0,     0,0, 1,0,1,0,0, 1,0,1,'h31);
    tbl[27] = mk(1,3,'hABCD, 0,0,0,     0,0, 1,0,1,1,0, 2,0,1,'h32);
    tbl[28] = mk(0,0,0,      0,0,0,     1,1, 0,0,0,0,0, 2,0,1,'hABCD);
    tbl[29] = mk(0,0,0,      0,0,0,     0,0, 0,0,0,0,1, 2,0,0,-1);
    tbl[30] = mk(0,0,0,      1,2,0,     0,1, 0,0,0,0,0, 0,0,0,-1);
    tbl[31] = mk(0,0,0,      0,0,0,     0,0, 0,0,0,0,0, 0,0,1,-1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst srst", int'(stk_rst), 1);
    chk("rst depth", int'(depth), 0);
    chk("rst flags", int'({ovf, unf}), 0);

    // Directed table; the first entry is the first cycle out of reset.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) resetq = 1'b1;
      drive(tbl[i].cr, tbl[i].cop, tbl[i].cd, tbl[i].dr, tbl[i].dop, tbl[i].dd,
            tbl[i].fl, tbl[i].ce);
      #1;
      chk($sformatf("v%0d core_gnt", i), int'(bus.core_gnt), int'(tbl[i].cg));
      chk($sformatf("v%0d dbg_gnt", i), int'(bus.dbg_gnt), int'(tbl[i].dg));
      chk($sformatf("v%0d stk_push", i), int'(stk_push), int'(tbl[i].sp));
      chk($sformatf("v%0d stk_pop", i), int'(stk_pop), int'(tbl[i].spo));
      chk($sformatf("v%0d stk_rst", i), int'(stk_rst), int'(tbl[i].srst));
      chk($sformatf("v%0d depth", i), int'(depth), tbl[i].dep);
      chk($sformatf("v%0d empty", i), int'(empty), int'(tbl[i].dep == 0));
      chk($sformatf("v%0d full", i), int'(full), int'(tbl[i].dep == 8));
      chk($sformatf("v%0d ovf", i), int'(ovf), int'(tbl[i].ov));
      chk($sformatf("v%0d unf", i), int'(unf), int'(tbl[i].un));
      if (tbl[i].cg) chk($sformatf("v%0d stk_in", i), int'(stk_in), int'(tbl[i].cd));
      if (tbl[i].dg) chk($sformatf("v%0d stk_in", i), int'(stk_in), int'(tbl[i].dd));
      if (tbl[i].top >= 0) chk_top($sformatf("v%0d top", i), tbl[i].top);
    end

    // Reset asserted in the middle of a cycle with a push pending.
    @(negedge clk);
    drive(1, 1, 'h77, 0, 0, 0, 0, 0);
    #1 chk("pre-rst gnt", int'(bus.core_gnt), 1);
    @(negedge clk);
    #1 chk("pre-rst depth", int'(depth), 1);
    #1 resetq = 1'b0;
    #1;
    chk("mid-rst core_gnt", int'(bus.core_gnt), 0);
    chk("mid-rst stk_push", int'(stk_push), 0);
    chk("mid-rst stk_rst", int'(stk_rst), 1);
    chk("mid-rst depth", int'(depth), 0);
    chk("mid-rst unf", int'(unf), 0);
    chk("mid-rst empty", int'(empty), 1);

    // Randomized run against the reference model, starting from reset.
    m_q.delete();
    m_flushing = 1; m_halted = 0; m_core_next = 1; m_ovf = 0; m_unf = 0;
    for (int c = 0; c < 400; c++) begin
      logic cr, dr, fl, ce, e_cg, e_dg, c_ok, d_ok, c_err, d_err, busy, clr_eff;
      logic [1:0] cop, dop, op;
      logic [15:0] cd, dd, din;
      int n;
      @(negedge clk);
      if (c == 0) resetq = 1'b1;
      cr = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) == 0);
      cop = 2'($urandom_range(0, 3));
      dop = 2'($urandom_range(0, 3));
      cd = 16'($urandom);
      dd = 16'($urandom);
      fl = ($urandom_range(0, 24) == 0);
      ce = ($urandom_range(0, 7) == 0);
      drive(cr, cop, cd, dr, dop, dd, fl, ce);
      #1;
      n = m_q.size();
      busy  = m_flushing || fl;
      c_ok  = !busy && !m_halted && cr && m_legal(cop, n);
      d_ok  = !busy && dr && m_legal(dop, n);
      c_err = !busy && !m_halted && cr && cop != 0 && !m_legal(cop, n);
      d_err = !busy && dr && dop != 0 && !m_legal(dop, n);
      e_cg  = c_ok && (!d_ok || m_core_next);
      e_dg  = d_ok && !e_cg;
      op    = e_cg ? cop : (e_dg ? dop : 2'b00);
      din   = e_cg ? cd : (e_dg ? dd : 16'h0);
      chk("rnd core_gnt", int'(bus.core_gnt), int'(e_cg));
      chk("rnd dbg_gnt", int'(bus.dbg_gnt), int'(e_dg));
      chk("rnd push/pop", int'({stk_push, stk_pop}), int'({op[0], op[1]}));
      chk("rnd stk_in", int'(stk_in), int'(din));
      chk("rnd stk_rst", int'(stk_rst), int'(m_flushing));
      chk("rnd depth", int'(depth), n);
      chk("rnd empty/full", int'({empty, full}), int'({n == 0, n == 8}));
      chk("rnd ovf/unf", int'({ovf, unf}), int'({m_ovf, m_unf}));
      if (n > 0 && !m_flushing) chk_top("rnd top", int'(m_q[n-1]));
      // advance the model across the clock edge
      if (e_cg || e_dg) begin
        m_core_next = e_dg;
        if (op == 2'b01) m_q.push_back(din);
        else if (op == 2'b10) void'(m_q.pop_back());
        else m_q[n-1] = din;
      end
      clr_eff = ce && !m_flushing;
      m_ovf = (m_ovf && !clr_eff) || (c_err && cop == 2'b01) || (d_err && dop == 2'b01);
      m_unf = (m_unf && !clr_eff) || (c_err && cop != 2'b01) || (d_err && dop != 2'b01);
      if (m_flushing) begin
        m_flushing = 0; m_halted = 0; m_q.delete();
      end else if (fl) begin
        m_flushing = 1; m_halted = 0;
      end else if (c_err) m_halted = 1;
      else if (ce) m_halted = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctl.md
STACK_CTL -- requirements
Module: stack_ctl

Interface
REQ-001 Parameter WIDTH, default 16, stack cell width in bits.
REQ-002 Parameter DEPTHLOG2, default 3, log2 of stack depth; DEPTH = 2**DEPTHLOG2.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetq  in  1  asynchronous, active-low reset.
REQ-005 core_req  in  1  core requests one stack operation this cycle.
REQ-006 core_op  in  2  core operation: 01 push, 10 pop, 11 replace (pop+push), 00 no-op.
REQ-007 core_din  in  WIDTH  core push/replace data.
REQ-008 core_gnt  out  1  core operation accepted and issued this cycle.
REQ-009 dbg_req, dbg_op, dbg_din  in  1/2/WIDTH  debug-port request, same encoding as the core port.
REQ-010 dbg_gnt  out  1  debug operation accepted and issued this cycle.
REQ-011 flush  in  1  pulse; empties the stack.
REQ-012 clr_err  in  1  clears the sticky error flags and the halt state.
REQ-013 stk_push, stk_pop  out  1 each  drive the stack datapath push and pop inputs.
REQ-014 stk_in  out  WIDTH  data to the stack datapath.
REQ-015 stk_rst  out  1  synchronous active-high reset to the stack datapath pointer.
REQ-016 depth  out  DEPTHLOG2+1  current occupancy, 0..DEPTH.
REQ-017 empty, full  out  1 each  depth==0 and depth==DEPTH, respectively.
REQ-018 ovf, unf  out  1 each  sticky overflow and underflow flags.

Function
REQ-019 The FSM SHALL have three states: FLUSH, RUN and HALT.
REQ-020 In FLUSH: stk_rst=1; no grants; depth<=0; next state RUN.
REQ-021 In RUN, any flush=1 SHALL move the FSM to FLUSH at the next edge, and no grant SHALL be issued in that cycle.
REQ-022 Legal op: push with depth<DEPTH; pop with depth>0; replace with depth>0. No-op is never granted.
REQ-023 Arbitration is round-robin between core and dbg over legal requests, at most one grant per cycle; gnt is combinational in the same cycle as req.
REQ-024 The requester not granted last SHALL win a tie; after reset the core wins the first tie.
REQ-025 For the granted op, the block SHALL drive stk_push/stk_pop combinationally from op bits [0]/[1] and set stk_in to the granter's din; otherwise all three are 0.
REQ-026 Depth update at the edge: push +1, pop -1, replace unchanged; new stack data appears on the datapath out one cycle later.
REQ-027 On a core push when full, or a core pop/replace when empty: no grant, ovf or unf set at the next edge, and the FSM moves to HALT.
REQ-028 On an illegal dbg op: no grant and the corresponding ovf/unf flag set, but no HALT.
REQ-029 In HALT, core_gnt SHALL be 0, while dbg SHALL continue to be served with the same legality rules.
REQ-030 clr_err in HALT or RUN SHALL clear ovf/unf at the next edge; in HALT it returns the FSM to RUN.
REQ-031 flush in HALT SHALL move the FSM to FLUSH, which then returns to RUN; ovf/unf are not cleared by flush.
REQ-032 If clr_err and an error event occur in the same cycle, the error SHALL win and the flag is set.
REQ-033 If flush and clr_err occur in the same cycle, both SHALL take effect.

Reset
REQ-034 While resetq=0: state=FLUSH, depth=0, ovf=unf=0, round-robin pointer=core, stk_rst=1, gnts=0, stk_push=stk_pop=0.
REQ-035 The first cycle after resetq deasserts SHALL be a FLUSH cycle, which synchronises the datapath pointer; RUN starts on the second cycle.

Structure
REQ-036 A shared package SHALL hold the op encoding constants (OP_NOP, OP_PUSH, OP_POP, OP_REPL) and the FSM state encoding.
REQ-037 stack_ctl SHALL instantiate no datapath; one sub-module, stack_rr_arb (two-way round-robin arbiter), is natural.

Verification
REQ-038 Reset, then 8 core pushes 0x0001..0x0008 -> 8 grants, depth=8, full=1; the datapath top reads 0x0008 one cycle after the last grant.
REQ-039 Full stack, core push 0x0009 -> core_gnt=0, ovf=1, HALT; dbg pop is granted and depth becomes 7; clr_err -> RUN, ovf=0.
REQ-040 Core and dbg both request push on 4 consecutive cycles from empty -> grants alternate core,dbg,core,dbg and depth=4.
REQ-041 depth=3, flush -> one cycle with stk_rst=1 and no grants, then depth=0 and empty=1; a dbg pop then yields unf=1 with no HALT.
REQ-042 depth=2, core replace 0xABCD -> grant issued, stk_push=stk_pop=1, depth stays 2, top=0xABCD; resetq asserted mid-sequence -> all outputs at REQ-034 values immediately.
